kernel_dispatch: RTL and testbench

Job initiator for the kernel convolution unit: accepts one pixel window at a time over a valid/ready handshake, latches it with a stored kernel, and sequences the unit's clear → start → done protocol. Each completed job yields one 8-bit pixel on a valid/ready result port. It sits between the window-gathering front end and the convolution unit, and guarantees the unit sees a clean accumulator and a fresh rising edge on `start` for every window.

---
 rtl/kernel_dispatch.sv | 163 ++++++++++++++++
 tb/tb_kernel_dispatch.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_dispatch.sv
// Job initiator for the kernel convolution unit: latches one window plus the stored kernel and
// walks the unit through clear -> gap -> start -> done, returning one pixel per job.
module kernel_dispatch #(
    parameter int unsigned MAX_KERNEL = 3,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cfg_we,
    input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] cfg_kernel,
    input  logic [$clog2(MAX_KERNEL)-1:0]            cfg_size,
    input  logic                                     win_valid,
    output logic                                     win_ready,
    input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] win_data,
    output logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] ck_matrix,
    output logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] ck_kernel,
    output logic [$clog2(MAX_KERNEL)-1:0]            ck_size,
    output logic                                     ck_clear,
    input  logic                                     ck_clear_flag,
    output logic                                     ck_start,
    input  logic                                     ck_done,
    input  logic [7:0]                               ck_pixel,
    output logic                                     res_valid,
    input  logic                                     res_ready,
    output logic [7:0]                               res_pixel,
    output logic                                     busy,
    output logic                                     timeout_err,
    output logic [15:0]                              job_count
);

    localparam int unsigned SizeW = $clog2(MAX_KERNEL);
    localparam int unsigned CntW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StClear, StGap, StRun, StOut} state_e;

    typedef logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] mat_t;

    state_e          state_q, state_d;
    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tmo_hit, tmo_abort;

    logic win_ready_q, win_ready_d;
    logic ck_clear_q, ck_clear_d;
    logic ck_start_q, ck_start_d;
    logic res_valid_q, res_valid_d;
    logic busy_q, busy_d;

    mat_t             matrix_q, kernel_q;
    logic [SizeW-1:0] size_q;
    logic [7:0]       res_pixel_q;
    logic             timeout_err_q;
    logic [15:0]      job_count_q;

    assign tmo_hit = (tmo_cnt_q == CntW'(TIMEOUT - 1));

    // State, timeout counter and handshake/control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tmo_cnt_q   <= '0;
            win_ready_q <= 1'b1;
            ck_clear_q  <= 1'b0;
            ck_start_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            win_ready_q <= win_ready_d;
            ck_clear_q  <= ck_clear_d;
            ck_start_q  <= ck_start_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_abort = 1'b0;
        case (state_q)
            StIdle: begin
                if (win_valid) state_d = StClear;
            end
            StClear: begin
                if (ck_clear_flag) begin
                    state_d = StGap;
                end else if (tmo_hit) begin
                    state_d   = StIdle;
                    tmo_abort = 1'b1;
                end
            end
            StGap: state_d = StRun;
            StRun: begin
                if (ck_done) begin
                    state_d = StOut;
                end else if (tmo_hit) begin
                    state_d   = StIdle;
                    tmo_abort = 1'b1;
                end
            end
            StOut: begin
                if (res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Any state change restarts the count, so it is zero on entry to CLEAR and RUN.
        tmo_cnt_d = '0;
        if ((state_d == state_q) && ((state_q == StClear) || (state_q == StRun))) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Outputs decoded from the next state so every port comes straight from a flop.
    always_comb begin
        win_ready_d = (state_d == StIdle);
        ck_clear_d  = (state_d == StClear);
        ck_start_d  = (state_d == StRun);
        res_valid_d = (state_d == StOut);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            matrix_q      <= '0;
            kernel_q      <= '0;
            size_q        <= '0;
            res_pixel_q   <= '0;
            timeout_err_q <= 1'b0;
            job_count_q   <= '0;
        end else begin
            if ((state_q == StIdle) && cfg_we) begin
                kernel_q <= cfg_kernel;
                size_q   <= cfg_size;
            end
            if ((state_q == StIdle) && win_valid) begin
                matrix_q <= win_data;
            end
            if ((state_q == StRun) && ck_done) begin
                res_pixel_q <= ck_pixel;
            end
            if ((state_q == StOut) && res_ready) begin
                job_count_q <= job_count_q + 16'd1;
            end
            if (tmo_abort) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign win_ready   = win_ready_q;
    assign ck_clear    = ck_clear_q;
    assign ck_start    = ck_start_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign ck_matrix   = matrix_q;
    assign ck_kernel   = kernel_q;
    assign ck_size     = size_q;
    assign res_pixel   = res_pixel_q;
    assign timeout_err = timeout_err_q;
    assign job_count   = job_count_q;

endmodule

// File: tb/tb_kernel_dispatch.sv
// Randomised bench for kernel_dispatch: plays the convolution unit and downstream sink,
// predicting every output from the job-level protocol rules.
module tb_kernel_dispatch;

    localparam int unsigned MK  = 3;
    localparam int unsigned TMO = 64;
    localparam int unsigned SW  = $clog2(MK);

    typedef logic [MK-1:0][MK-1:0][7:0] mat_t;

    logic          clk = 1'b0;
    logic          rst, cfg_we, win_valid, win_ready, ck_clear, ck_clear_flag, ck_start;
    logic          ck_done, res_valid, res_ready, busy, timeout_err;
    mat_t          cfg_kernel, win_data, ck_matrix, ck_kernel;
    logic [SW-1:0] cfg_size, ck_size;
    logic [7:0]    ck_pixel, res_pixel;
    logic [15:0]   job_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what the block must be holding at job level.
    mat_t          m_kernel;
    logic [SW-1:0] m_size;
    logic [15:0]   m_jobs;
    logic          m_err;

    always #5 clk = ~clk;

    kernel_dispatch #(
        .MAX_KERNEL (MK),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_kernel    (cfg_kernel),
        .cfg_size      (cfg_size),
        .win_valid     (win_valid),
        .win_ready     (win_ready),
        .win_data      (win_data),
        .ck_matrix     (ck_matrix),
        .ck_kernel     (ck_kernel),
        .ck_size       (ck_size),
        .ck_clear      (ck_clear),
        .ck_clear_flag (ck_clear_flag),
        .ck_start      (ck_start),
        .ck_done       (ck_done),
        .ck_pixel      (ck_pixel),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_pixel     (res_pixel),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .job_count     (job_count)
    );

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < MK; i++) begin
            for (int j = 0; j < MK; j++) begin
                m[i][j] = 8'($urandom);
            end
        end
        return m;
    endfunction

    function automatic mat_t fill_mat(input logic [7:0] v);
        mat_t m;
        for (int i = 0; i < MK; i++) begin
            for (int j = 0; j < MK; j++) begin
                m[i][j] = v;
            end
        end
        return m;
    endfunction

    // The unit never sees two starts without at least IDLE, CLEAR and GAP in between.
    int   lowrun     = 100;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (ck_start && !prev_start) check("start_gap_ge3", 80'(lowrun >= 3), 80'd1);
        lowrun     = ck_start ? 0 : lowrun + 1;
        prev_start = ck_start;
    end

    task automatic check_idle(input string tag);
        check({tag, "_win_ready"}, win_ready, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ck_clear"}, ck_clear, 1'b0);
        check({tag, "_ck_start"}, ck_start, 1'b0);
        check({tag, "_res_valid"}, res_valid, 1'b0);
        check({tag, "_timeout_err"}, timeout_err, m_err);
        check({tag, "_job_count"}, job_count, m_jobs);
    endtask

    // One complete job. clr_dly/done_dly: cycles the unit waits in CLEAR/RUN before answering
    // (>= TMO means it never answers). res_wait: cycles of downstream backpressure.
    task automatic run_job(input mat_t win, input logic we, input mat_t kern,
                           input logic [SW-1:0] sz, input int clr_dly, input int done_dly,
                           input logic [7:0] pix, input int res_wait, input logic run_we);
        int   k;
        logic aborted;
        check_idle("pre");
        win_valid  = 1'b1;
        win_data   = win;
        cfg_we     = we;
        cfg_kernel = kern;
        cfg_size   = sz;
        if (we) begin
            m_kernel = kern;
            m_size   = sz;
        end
        step();
        win_valid = 1'b0;
        cfg_we    = 1'b0;
        win_data  = rand_mat();
        check("acc_matrix", ck_matrix, win);
        check("acc_kernel", ck_kernel, m_kernel);
        check("acc_size", ck_size, m_size);
        check("acc_win_ready", win_ready, 1'b0);
        check("acc_busy", busy, 1'b1);

        k       = 0;
        aborted = 1'b0;
        forever begin
            check("clr_level", ck_clear, 1'b1);
            check("clr_nostart", ck_start, 1'b0);
            ck_clear_flag = (k == clr_dly);
            ck_done       = 1'($urandom);
            step();
            ck_clear_flag = 1'b0;
            ck_done       = 1'b0;
            if (k == clr_dly) break;
            if (k == TMO - 1) begin
                aborted = 1'b1;
                break;
            end
            k++;
        end
        if (aborted) begin
            m_err = 1'b1;
            check_idle("clr_tmo");
            return;
        end

        check("gap_clear", ck_clear, 1'b0);
        check("gap_start", ck_start, 1'b0);
        check("gap_busy", busy, 1'b1);
        ck_done = 1'($urandom);
        step();
        ck_done = 1'b0;

        k = 0;
        forever begin
            check("run_start", ck_start, 1'b1);
            check("run_noclear", ck_clear, 1'b0);
            check("run_res_valid", res_valid, 1'b0);
            if (k == 1) check("run_kernel_hold", ck_kernel, m_kernel);
            if (k == 0 && run_we) begin
                cfg_we     = 1'b1;
                cfg_kernel = rand_mat();
                cfg_size   = SW'($urandom);
            end
            ck_clear_flag = 1'($urandom);
            ck_done       = (k == done_dly);
            ck_pixel      = (k == done_dly) ? pix : 8'($urandom);
            step();
            cfg_we        = 1'b0;
            ck_done       = 1'b0;
            ck_clear_flag = 1'b0;
            if (k == done_dly) break;
            if (k == TMO - 1) begin
                aborted = 1'b1;
                break;
            end
            k++;
        end
        if (aborted) begin
            m_err = 1'b1;
            check_idle("run_tmo");
            return;
        end

        for (int w = 0; w <= res_wait; w++) begin
            check("out_valid", res_valid, 1'b1);
            check("out_pixel", res_pixel, pix);
            check("out_win_ready", win_ready, 1'b0);
            check("out_start", ck_start, 1'b0);
            check("out_matrix", ck_matrix, win);
            check("out_kernel", ck_kernel, m_kernel);
            check("out_size", ck_size, m_size);
            check("out_job_count", job_count, m_jobs);
            res_ready = (w == res_wait);
            win_valid = (w < res_wait) ? 1'($urandom) : 1'b0;
            win_data  = rand_mat();
            step();
        end
        res_ready = 1'b0;
        win_valid = 1'b0;
        m_jobs    = m_jobs + 16'd1;
        check_idle("post");
    endtask

    initial begin
        rst           = 1'b1;
        cfg_we        = 1'b0;
        cfg_kernel    = '0;
        cfg_size      = '0;
        win_valid     = 1'b0;
        win_data      = '0;
        ck_clear_flag = 1'b0;
        ck_done       = 1'b0;
        ck_pixel      = '0;
        res_ready     = 1'b0;
        m_kernel      = '0;
        m_size        = '0;
        m_jobs        = '0;
        m_err         = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        check_idle("reset");
        check("reset_res_pixel", res_pixel, 8'h00);
        check("reset_matrix", ck_matrix, 72'h0);
        check("reset_kernel", ck_kernel, 72'h0);
        check("reset_size", ck_size, 2'd0);
        step();
        check_idle("idle");

        // Directed single job: kernel of ones, size 2, window of 0x10.
        run_job(fill_mat(8'h10), 1'b1, fill_mat(8'h01), 2'd2, 2, 9, 8'h5A, 0, 1'b0);
        check("single_job_count", job_count, 16'd1);
        check("single_res_pixel", res_pixel, 8'h5A);

        // Back-to-back with immediate result acceptance.
        repeat (3) run_job(rand_mat(), 1'b0, rand_mat(), 2'd0, 0, $urandom_range(0, 3),
                           8'($urandom), 0, 1'b0);

        // Ten cycles of result backpressure.
        run_job(rand_mat(), 1'b1, rand_mat(), 2'd1, 1, 3, 8'($urandom), 10, 1'b0);

        // Unit never finishes; next job must still run with the error flag held.
        run_job(rand_mat(), 1'b0, rand_mat(), 2'd0, 0, 1000, 8'h00, 0, 1'b0);
        run_job(rand_mat(), 1'b0, rand_mat(), 2'd0, 1, 4, 8'hC3, 1, 1'b0);

        // Config write during RUN is ignored.
        run_job(rand_mat(), 1'b1, rand_mat(), 2'd2, 0, 5, 8'($urandom), 0, 1'b1);

        // Unit never acknowledges the clear.
        run_job(rand_mat(), 1'b0, rand_mat(), 2'd0, 500, 0, 8'h00, 0, 1'b0);

        repeat (25) begin
            automatic int clr = ($urandom_range(0, 9) == 0) ? 200 : int'($urandom_range(0, 4));
            automatic int dn  = ($urandom_range(0, 7) == 0) ? 200 : int'($urandom_range(0, 12));
            run_job(rand_mat(), 1'($urandom), rand_mat(), SW'($urandom), clr, dn,
                    8'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        // Reset while RUN is active.
        win_valid = 1'b1;
        win_data  = rand_mat();
        step();
        win_valid     = 1'b0;
        ck_clear_flag = 1'b1;
        step();
        ck_clear_flag = 1'b0;
        step();
        check("rst_pre_start", ck_start, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        m_jobs   = '0;
        m_err    = 1'b0;
        m_kernel = '0;
        m_size   = '0;
        check_idle("midrst");
        check("midrst_matrix", ck_matrix, 72'h0);
        check("midrst_kernel", ck_kernel, 72'h0);
        check("midrst_res_pixel", res_pixel, 8'h00);

        run_job(rand_mat(), 1'b1, rand_mat(), 2'd1, 2, 2, 8'h77, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
